trap_commit_ctrl: RTL

- Trap and commit sequencer that drives the commit-side write port of the CSR register file.
- Detects ecall, ebreak, mret and external interrupts at the execute stage.
- Stalls the pipeline while it performs multi-cycle CSR write-back of mepc, mstatus and mcause.
- Issues a one-cycle redirect to the trap vector or return address.

---
 rtl/trap_commit_if.sv | 41 ++++
 rtl/trap_commit_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/trap_commit_if.sv
// trap_commit_if: execute-stage, CSR and commit/redirect signals of the
// trap/commit sequencer, bundled as one interface.
//   slave  : sequencer side (trap_commit_ctrl)
//   master : pipeline / CSR file side
// Inputs to the sequencer: inst_i, inst_addr_i, jump_flag_i, jump_addr_i,
//   int_flag_i[INT_W], csr_mtvec, csr_mepc, csr_mstatus, global_int_en_i.
// Outputs: hold_flag_o, commit_wen_o, commit_waddr_o, commit_wdata_o,
//   int_assert_o, int_addr_o.
interface trap_commit_if #(
    parameter int INT_W = 8
);
    logic [31:0]      inst_i;
    logic [31:0]      inst_addr_i;
    logic             jump_flag_i;
    logic [31:0]      jump_addr_i;
    logic [INT_W-1:0] int_flag_i;
    logic [31:0]      csr_mtvec;
    logic [31:0]      csr_mepc;
    logic [31:0]      csr_mstatus;
    logic             global_int_en_i;
    logic             hold_flag_o;
    logic             commit_wen_o;
    logic [31:0]      commit_waddr_o;
    logic [31:0]      commit_wdata_o;
    logic             int_assert_o;
    logic [31:0]      int_addr_o;

    modport slave (
        input  inst_i, inst_addr_i, jump_flag_i, jump_addr_i, int_flag_i,
               csr_mtvec, csr_mepc, csr_mstatus, global_int_en_i,
        output hold_flag_o, commit_wen_o, commit_waddr_o, commit_wdata_o,
               int_assert_o, int_addr_o
    );

    modport master (
        output inst_i, inst_addr_i, jump_flag_i, jump_addr_i, int_flag_i,
               csr_mtvec, csr_mepc, csr_mstatus, global_int_en_i,
        input  hold_flag_o, commit_wen_o, commit_waddr_o, commit_wdata_o,
               int_assert_o, int_addr_o
    );
endinterface

// File: rtl/trap_commit_ctrl.sv
// trap_commit_ctrl: detects ecall / ebreak / mret / external interrupt in
// execute, stalls the pipeline while mepc, mstatus and mcause are written
// back through the CSR commit port, then issues a one-cycle redirect.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : trap_commit_if.slave (execute inputs, CSR values, commit
//              write port, hold and redirect outputs)
// Optional feature macro TRAP_VECTORED_EN: vectored mtvec mode for
// interrupts (base + cause*4); when undefined every trap uses the base.
// INT_W must match the INT_W of the connected interface.
module trap_commit_ctrl #(
    parameter int          INT_W        = 8,
    parameter logic [31:0] ECALL_CODE   = 32'd11,
    parameter logic [31:0] EBREAK_CODE  = 32'd3,
    parameter logic [31:0] EXT_INT_CODE = 32'h8000000B
) (
    input  logic           clk,
    input  logic           rst,
    trap_commit_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, W_MRET, ASSERT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] epc_q, epc_d, cause_q, cause_d, mstatus_q, mstatus_d;
    logic        wen_q, wen_d, assert_q, assert_d;
    logic [31:0] waddr_q, waddr_d, wdata_q, wdata_d, addr_q, addr_d;
    logic        hold;

    logic [INT_W-1:0] irq;
    logic [31:0]      ms, trap_ms, mret_ms, trap_addr;
    logic             is_ecall, is_ebreak, is_mret, is_int;

    assign irq = bus.int_flag_i;
    assign ms  = bus.csr_mstatus;

    assign is_ecall  = bus.inst_i == 32'h00000073;
    assign is_ebreak = bus.inst_i == 32'h00100073;
    assign is_mret   = bus.inst_i == 32'h30200073;
    // System-opcode instructions defer the interrupt so an execute-stage
    // CSR write in the same cycle cannot race the commit writes.
    assign is_int    = (|irq) && bus.global_int_en_i &&
                       (bus.inst_i[6:0] != 7'b1110011);

    // Trap: MPIE<=MIE, MIE<=0.  MRET: MIE<=MPIE, MPIE<=1.
    assign trap_ms = {ms[31:8], ms[3], ms[6:4], 1'b0, ms[2:0]};
    assign mret_ms = {ms[31:8], 1'b1, ms[6:4], ms[7], ms[2:0]};

`ifdef TRAP_VECTORED_EN
    always_comb begin
        trap_addr = {bus.csr_mtvec[31:2], 2'b00};
        if (bus.csr_mtvec[1:0] == 2'b01 && cause_q[31])
            trap_addr = {bus.csr_mtvec[31:2], 2'b00} + {cause_q[29:0], 2'b00};
    end
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = &{1'b0, bus.csr_mtvec[1:0]};
    assign trap_addr = {bus.csr_mtvec[31:2], 2'b00};
`endif

    always_comb begin
        state_d   = state_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        mstatus_d = mstatus_q;
        hold      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (is_ecall || is_ebreak) begin
                    state_d   = W_MEPC;
                    epc_d     = bus.inst_addr_i;
                    cause_d   = is_ecall ? ECALL_CODE : EBREAK_CODE;
                    mstatus_d = trap_ms;
                    hold      = 1'b1;
                end else if (is_mret) begin
                    state_d   = W_MRET;
                    mstatus_d = mret_ms;
                    hold      = 1'b1;
                end else if (is_int) begin
                    state_d   = W_MEPC;
                    epc_d     = bus.jump_flag_i ? bus.jump_addr_i
                                                : bus.inst_addr_i + 32'd4;
                    cause_d   = EXT_INT_CODE;
                    mstatus_d = trap_ms;
                    hold      = 1'b1;
                end
            end
            W_MEPC:    state_d = W_MSTATUS;
            W_MSTATUS: state_d = W_MCAUSE;
            W_MCAUSE:  state_d = ASSERT;
            W_MRET:    state_d = ASSERT;
            ASSERT:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        // Outputs are registered: decode them from the state being entered.
        wen_d    = 1'b0;
        waddr_d  = 32'h0;
        wdata_d  = 32'h0;
        assert_d = 1'b0;
        addr_d   = 32'h0;
        case (state_d)
            W_MEPC:    begin wen_d = 1'b1; waddr_d = 32'h341; wdata_d = epc_d;     end
            W_MSTATUS: begin wen_d = 1'b1; waddr_d = 32'h300; wdata_d = mstatus_d; end
            W_MCAUSE:  begin wen_d = 1'b1; waddr_d = 32'h342; wdata_d = cause_d;   end
            W_MRET:    begin wen_d = 1'b1; waddr_d = 32'h300; wdata_d = mstatus_d; end
            ASSERT: begin
                assert_d = 1'b1;
                addr_d   = (state_q == W_MRET) ? bus.csr_mepc : trap_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            epc_q     <= 32'h0;
            cause_q   <= 32'h0;
            mstatus_q <= 32'h0;
            wen_q     <= 1'b0;
            waddr_q   <= 32'h0;
            wdata_q   <= 32'h0;
            assert_q  <= 1'b0;
            addr_q    <= 32'h0;
        end else begin
            state_q   <= state_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            mstatus_q <= mstatus_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            assert_q  <= assert_d;
            addr_q    <= addr_d;
        end
    end

    assign bus.hold_flag_o    = hold;
    assign bus.commit_wen_o   = wen_q;
    assign bus.commit_waddr_o = waddr_q;
    assign bus.commit_wdata_o = wdata_q;
    assign bus.int_assert_o   = assert_q;
    assign bus.int_addr_o     = addr_q;
endmodule
